// File: rtl/uart_responder.sv
// 8N1 UART endpoint: strobe-driven TX serialiser plus RX deserialiser feeding a show-ahead FIFO.
// Optional internal TX->RX loopback is enabled by defining UART_LOOPBACK_EN.
module uart_responder #(
  parameter int CLKS_PER_BIT = 104,
  parameter int RX_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       uart0_wr,
  input  logic [7:0] uart_w,
  output logic       uart0_busy,
  input  logic       uart0_rd,
  output logic       uart0_valid,
  output logic [7:0] uart0_data,
  output logic       uart_tx,
  input  logic       uart_rx
`ifdef UART_LOOPBACK_EN
  ,
  input  logic       loopback
`endif
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] LP_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] LP_HALF = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      r_tx_state;
  logic [15:0] r_tx_cnt;
  logic [2:0]  r_tx_idx;
  logic [7:0]  r_tx_shift;
  logic        r_tx_line;
  logic        r_busy;

  state_t      r_rx_state;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_idx;
  logic [7:0]  r_rx_shift;
  logic        r_rx_brk;
  logic        r_rx_s1;
  logic        r_rx_s2;

  logic [7:0]  r_mem [RX_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_rx_in;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_wr;

`ifdef UART_LOOPBACK_EN
  assign w_rx_in = loopback ? r_tx_line : uart_rx;
  assign uart_tx = loopback | r_tx_line;
`else
  assign w_rx_in = uart_rx;
  assign uart_tx = r_tx_line;
`endif

  assign uart0_busy = r_busy;

  always_ff @(posedge clk) begin
    if (resetq) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_tx_line  <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      case (r_tx_state)
        S_IDLE: begin
          if (uart0_wr) begin
            r_tx_shift <= uart_w;
            r_tx_line  <= 1'b0;
            r_busy     <= 1'b1;
            r_tx_cnt   <= '0;
            r_tx_state <= S_START;
          end
        end
        S_START: begin
          if (r_tx_cnt == LP_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_line  <= r_tx_shift[0];
            r_tx_state <= S_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (r_tx_cnt == LP_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_idx == 3'd7) begin
              r_tx_line  <= 1'b1;
              r_tx_state <= S_STOP;
            end else begin
              r_tx_idx   <= r_tx_idx + 3'd1;
              r_tx_line  <= r_tx_shift[1];
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (r_tx_cnt == LP_LAST) begin
            r_tx_cnt   <= '0;
            r_busy     <= 1'b0;
            r_tx_state <= S_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
          end
        end
        default: r_tx_state <= S_IDLE;
      endcase
    end
  end

  // A low stop bit parks the FSM in STOP until the line returns high, so a break cannot retrigger.
  always_ff @(posedge clk) begin
    if (resetq) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      r_rx_brk   <= 1'b0;
    end else begin
      r_rx_s1 <= w_rx_in;
      r_rx_s2 <= r_rx_s1;
      case (r_rx_state)
        S_IDLE: begin
          if (!r_rx_s2) begin
            r_rx_cnt   <= '0;
            r_rx_state <= S_START;
          end
        end
        S_START: begin
          if (r_rx_cnt == LP_HALF) begin
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (r_rx_cnt == LP_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            if (r_rx_idx == 3'd7) r_rx_state <= S_STOP;
            else                  r_rx_idx   <= r_rx_idx + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (r_rx_brk) begin
            if (r_rx_s2) begin
              r_rx_brk   <= 1'b0;
              r_rx_state <= S_IDLE;
            end
          end else if (r_rx_cnt == LP_LAST) begin
            r_rx_cnt <= '0;
            if (r_rx_s2) r_rx_state <= S_IDLE;
            else         r_rx_brk   <= 1'b1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  assign w_push = (r_rx_state == S_STOP) && !r_rx_brk && (r_rx_cnt == LP_LAST) && r_rx_s2;
  assign w_pop  = uart0_rd && (r_count != '0);
  assign w_full = (r_count == CW'(RX_DEPTH));
  // When full, a same-cycle pop frees the slot the push is about to use.
  assign w_wr   = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (resetq) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < RX_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= r_rx_shift;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign uart0_valid = (r_count != '0);
  assign uart0_data  = r_mem[r_rptr];

endmodule

// File: doc/uart_responder.md
Name: uart_responder

Overview:
- Device-side endpoint for the CPU's uart0 strobe interface: consumes uart0_wr/uart_w and answers with uart0_busy; supplies uart0_valid/uart0_data and consumes uart0_rd.
- Serialises TX bytes onto a pin and deserialises RX pin frames into a small show-ahead FIFO.
- Frame format is fixed 8N1.
- Sits beside the processor top level and drives the board UART pins directly.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per bit period; legal range 4..65535.
- RX_DEPTH, 4, RX FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  input  1  system clock
- resetq  input  1  synchronous reset, asserted high (codebase port name retained)
- uart0_wr  input  1  one-cycle write strobe; byte is uart_w
- uart_w  input  8  TX byte
- uart0_busy  output  1  high while the transmitter is occupied
- uart0_rd  input  1  one-cycle read strobe; pops the RX FIFO head
- uart0_valid  output  1  RX FIFO not empty
- uart0_data  output  8  RX FIFO head byte (show-ahead)
- uart_tx  output  1  serial out, idle high
- uart_rx  input  1  serial in, asynchronous

Behaviour:
- Reset values:
  - uart_tx=1, uart0_busy=0, uart0_valid=0, uart0_data=0.
  - FIFO empty; both FSMs IDLE; RX synchroniser flops=1.
- Reset mid-frame aborts the frame. The next cycle shows the reset values; a partial TX frame is truncated with the line high.
- TX FSM states: IDLE, START, DATA, STOP.
  - Entry: uart0_wr while busy=0 latches uart_w. On the next edge busy=1, uart_tx=0 and the state is START.
  - Each state holds for exactly CLKS_PER_BIT cycles, driven by a bit counter counting 0..CLKS_PER_BIT-1.
  - DATA: 8 bits, LSB first; a 3-bit index wraps 7->STOP.
  - STOP: uart_tx=1. busy clears on the edge that ends STOP.
  - Full frame is 10*CLKS_PER_BIT cycles from busy rising to busy falling.
  - A new uart0_wr is accepted in the first cycle busy=0, giving back-to-back frames with no idle gap.
  - uart0_wr while busy=1 is ignored: no state change, byte dropped.
- RX synchronisation: 2-flop synchroniser; the FSM uses the second flop (rx_s).
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: rx_s==0 -> START with counter cleared.
  - START: at counter==CLKS_PER_BIT/2-1 (integer division) sample rx_s.
    - 1 = glitch -> IDLE.
    - 0 -> DATA with counter cleared.
  - DATA: sample at counter==CLKS_PER_BIT-1 (mid-bit), shift in LSB-first; after 8 samples -> STOP.
  - STOP: sample at mid-bit.
    - 1 -> push the byte into the FIFO (if not full), then IDLE.
    - 0 -> framing error; byte discarded; state is IDLE only once rx_s==1 (break does not retrigger).
- FIFO:
  - Pointers are log2(RX_DEPTH) bits wide and wrap naturally; occupancy counter is log2(RX_DEPTH)+1 bits.
  - uart0_valid = (count!=0).
  - uart0_data is the head entry, combinational from the storage array and read pointer; 0 is not required when empty.
  - uart0_rd with valid=0 is ignored.
  - Push while full drops the new byte (overrun); existing contents are kept.
  - Push and pop in the same cycle:
    - full: both happen, count unchanged, no overrun.
    - empty: the push occurs and the pop is ignored.
  - Push latency: uart0_valid rises 1 cycle after the STOP sample cycle.
- TX and RX are fully independent; simultaneous wr and rd strobes are both honoured.

Optional Feature:
- Macro UART_LOOPBACK_EN.
- Defined:
  - Adds input port loopback (1 bit), placed after uart_rx.
  - When loopback=1, the RX synchroniser input is the internal TX line instead of uart_rx, and uart_tx is held at 1.
  - Switching loopback mid-frame is legal; a corrupted frame is either discarded or pushed as received, with no hang.
- Undefined: port absent; RX always fed from uart_rx.

Test Plan:
- TX timing (CLKS_PER_BIT=4): reset, then uart0_wr with uart_w=8'hA5.
  - uart_tx sequence per 4 cycles: 0,1,0,1,0,0,1,0,1,1.
  - busy high for exactly 40 cycles.
  - A second wr issued during busy is dropped.
- RX decode (CLKS_PER_BIT=4): drive 8'h3C as 8N1 on uart_rx.
  - uart0_valid rises; uart0_data=8'h3C.
  - uart0_rd clears valid next cycle.
- RX overrun (RX_DEPTH=4): send 8'h01..8'h05 with no reads.
  - 4 reads return 01,02,03,04, then valid=0; 05 is lost.
- Full with simultaneous push and pop: FIFO full with 10,11,12,13; pulse uart0_rd in the push cycle of 8'h14.
  - Reads return 11,12,13,14.
- RX glitch and framing error:
  - A 1-cycle low pulse on uart_rx produces no push.
  - A frame with stop bit 0 produces no push; a following valid 8'h7E is received correctly.
- Reset mid-frame: assert resetq at cycle 15 of a TX frame and during RX DATA.
  - Next cycle: uart_tx=1, busy=0, valid=0.
  - A subsequent 8'h55 round trip (UART_LOOPBACK_EN, loopback=1) returns 8'h55.
